// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the fetch PC, drives the instruction memory
// address and buffers (pc, instruction) pairs in a small queue drained by decode.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    fetch_en,
    output logic [31:0]             imem_pc,
    input  logic [31:0]             imem_instruction,
    input  logic                    redirect_valid,
    input  logic [31:0]             redirect_pc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_instruction,
    output logic [31:0]             out_pc,
    output logic [$clog2(QDEPTH):0] queue_count
);

    localparam int            PW      = $clog2(QDEPTH);
    localparam int            CW      = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(QDEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    logic [31:0]   fetch_pc_r;
    logic [31:0]   fetch_pc_nxt_s;
    logic [PW-1:0] rd_ptr_r;
    logic [PW-1:0] rd_ptr_nxt_s;
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] wr_ptr_nxt_s;
    logic [CW-1:0] count_r;
    logic [CW-1:0] count_nxt_s;
    logic [31:0]   pc_q_r    [QDEPTH];
    logic [31:0]   instr_q_r [QDEPTH];
    logic          pop_s;
    logic          push_s;
    logic [31:0]   redirect_target_s;

    // Outputs come straight from registers; the head is read from storage.
    assign imem_pc         = fetch_pc_r;
    assign out_valid       = (count_r != {CW{1'b0}});
    assign queue_count     = count_r;
    assign out_instruction = instr_q_r[rd_ptr_r];
    assign out_pc          = pc_q_r[rd_ptr_r];

    // Handshake decode and next-state for fetch PC, pointers and occupancy.
    always_comb begin
        redirect_target_s = redirect_pc & 32'hFFFF_FFFC;
        pop_s             = out_valid & out_ready;
        push_s            = fetch_en & ~redirect_valid & ((count_r < DEPTH_C) | pop_s);
        fetch_pc_nxt_s    = fetch_pc_r;
        rd_ptr_nxt_s      = rd_ptr_r;
        wr_ptr_nxt_s      = wr_ptr_r;
        count_nxt_s       = count_r;

        if (redirect_valid) begin
            // A coincident pop is still a completed transfer; the flush just discards the rest.
            fetch_pc_nxt_s = redirect_target_s;
            rd_ptr_nxt_s   = {PW{1'b0}};
            wr_ptr_nxt_s   = {PW{1'b0}};
            count_nxt_s    = {CW{1'b0}};
        end else begin
            if (push_s) begin
                fetch_pc_nxt_s = fetch_pc_r + 32'd4;
                wr_ptr_nxt_s   = wr_ptr_r + PTR_ONE;
            end else begin
                fetch_pc_nxt_s = fetch_pc_r;
                wr_ptr_nxt_s   = wr_ptr_r;
            end

            if (pop_s) begin
                rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
            end else begin
                rd_ptr_nxt_s = rd_ptr_r;
            end

            case ({push_s, pop_s})
                2'b10:   count_nxt_s = count_r + CNT_ONE;
                2'b01:   count_nxt_s = count_r - CNT_ONE;
                default: count_nxt_s = count_r;
            endcase
        end
    end

    // Control state: fetch PC, queue pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_r <= RESET_PC;
            rd_ptr_r   <= {PW{1'b0}};
            wr_ptr_r   <= {PW{1'b0}};
            count_r    <= {CW{1'b0}};
        end else begin
            fetch_pc_r <= fetch_pc_nxt_s;
            rd_ptr_r   <= rd_ptr_nxt_s;
            wr_ptr_r   <= wr_ptr_nxt_s;
            count_r    <= count_nxt_s;
        end
    end

    // Queue storage: captures the fetched word together with its PC.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < QDEPTH; i++) begin
                pc_q_r[i]    <= 32'h0000_0000;
                instr_q_r[i] <= 32'h0000_0000;
            end
        end else if (push_s) begin
            pc_q_r[wr_ptr_r]    <= fetch_pc_r;
            instr_q_r[wr_ptr_r] <= imem_instruction;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed test-plan scenarios plus a
// randomized phase checked against a queue-based reference model.
module tb_fetch_sequencer;

    localparam int          QDEPTH   = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] W0       = 32'h00A0_0093;
    localparam logic [31:0] W1       = 32'h00B0_0113;
    localparam logic [31:0] W2       = 32'h0020_81B3;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_en;
    logic [31:0] imem_pc;
    logic [31:0] imem_instruction;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instruction;
    logic [31:0] out_pc;
    logic [1:0]  queue_count;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_fpc;
    logic [63:0] mq[$];
    logic [63:0] dut_deliv[$];

    fetch_sequencer #(.RESET_PC(RESET_PC), .QDEPTH(QDEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .fetch_en         (fetch_en),
        .imem_pc          (imem_pc),
        .imem_instruction (imem_instruction),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_instruction  (out_instruction),
        .out_pc           (out_pc),
        .queue_count      (queue_count)
    );

    always #5 clk = ~clk;

    // Instruction memory: preloaded words at 0/4/8, an address hash elsewhere.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: mem_word = W0;
            32'h0000_0004: mem_word = W1;
            32'h0000_0008: mem_word = W2;
            default:       mem_word = a ^ 32'h5A5A_C3C3;
        endcase
    endfunction

    assign imem_instruction = mem_word(imem_pc);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [63:0] head;
        check_eq("imem_pc", imem_pc, m_fpc);
        check_eq("queue_count", 32'(queue_count), 32'(mq.size()));
        check_eq("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            head = mq[0];
            check_eq("out_pc", out_pc, head[63:32]);
            check_eq("out_instruction", out_instruction, head[31:0]);
        end
    endtask

    // One clock: predict with the model, record DUT transfers, advance, compare.
    task automatic step();
        logic        pop;
        logic        push;
        logic        rd;
        logic [31:0] rpc;
        #2;
        rd   = redirect_valid;
        rpc  = redirect_pc;
        pop  = (mq.size() != 0) && out_ready;
        push = fetch_en && !rd && ((mq.size() < QDEPTH) || pop);
        if (out_valid && out_ready) dut_deliv.push_back({out_pc, out_instruction});
        @(posedge clk);
        #1;
        if (rd) begin
            mq.delete();
            m_fpc = {rpc[31:2], 2'b00};
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back({m_fpc, mem_word(m_fpc)});
                m_fpc = m_fpc + 32'd4;
            end
        end
        check_model();
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        fetch_en       = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        #1;
        m_fpc = RESET_PC;
        mq.delete();
        check_eq("rst_imem_pc", imem_pc, RESET_PC);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_queue_count", 32'(queue_count), 32'd0);
        check_eq("rst_out_instruction", out_instruction, 32'd0);
        check_eq("rst_out_pc", out_pc, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        dut_deliv.delete();
    endtask

    task automatic check_deliv(input string tag, input int idx, input logic [31:0] pc, input logic [31:0] ins);
        logic [63:0] d;
        if (idx >= dut_deliv.size()) begin
            check_eq(tag, 32'(dut_deliv.size()), 32'(idx + 1));
        end else begin
            d = dut_deliv[idx];
            check_eq(tag, d[63:32], pc);
            check_eq(tag, d[31:0], ins);
        end
    endtask

    initial begin
        // 1. Reset and stream
        do_reset();
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        step(); check_eq("s1_pc0", out_pc, 32'h0); check_eq("s1_ins0", out_instruction, W0);
        step(); check_eq("s1_pc1", out_pc, 32'h4); check_eq("s1_ins1", out_instruction, W1);
        step(); check_eq("s1_pc2", out_pc, 32'h8); check_eq("s1_ins2", out_instruction, W2);

        // 2. Back-pressure, then 3. full queue with push and pop together
        do_reset();
        fetch_en  = 1'b1;
        out_ready = 1'b0;
        step(); step();
        check_eq("s2_count_full", 32'(queue_count), 32'd2);
        check_eq("s2_pc_frozen", imem_pc, 32'h8);
        step(); step(); step();
        check_eq("s2_pc_still", imem_pc, 32'h8);
        check_eq("s2_head_pc", out_pc, 32'h0);
        check_eq("s2_head_ins", out_instruction, W0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("s3_count_steady", 32'(queue_count), 32'd2);
        end
        check_deliv("s2_deliv0", 0, 32'h0, W0);
        check_deliv("s2_deliv1", 1, 32'h4, W1);
        check_deliv("s2_deliv2", 2, 32'h8, W2);
        check_eq("s3_deliv_count", 32'(dut_deliv.size()), 32'd3);
        fetch_en = 1'b0;
        step(); check_eq("s3_drain1", 32'(queue_count), 32'd1);
        step(); check_eq("s3_drain0", 32'(queue_count), 32'd0);

        // 4. Redirect coinciding with a pop, misaligned target
        do_reset();
        fetch_en  = 1'b1;
        out_ready = 1'b1;
        step(); step();
        check_eq("s4_head_pc", out_pc, 32'h4);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0006;
        step();
        check_eq("s4_valid", 32'(out_valid), 32'd0);
        check_eq("s4_count", 32'(queue_count), 32'd0);
        check_eq("s4_imem_pc", imem_pc, 32'h4);
        check_deliv("s4_popped", 1, 32'h4, W1);
        redirect_valid = 1'b0;
        step();
        check_eq("s4_next_pc", out_pc, 32'h4);
        check_eq("s4_next_ins", out_instruction, W1);

        // 5. Fetch disable with one queued word
        check_eq("s5_start_count", 32'(queue_count), 32'd1);
        fetch_en = 1'b0;
        step(); step(); step();
        check_eq("s5_valid", 32'(out_valid), 32'd0);
        check_eq("s5_imem_pc", imem_pc, 32'h8);

        // 6. PC wrap, then asynchronous reset mid-cycle
        fetch_en       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        step(); check_eq("s6_pc_top", out_pc, 32'hFFFF_FFFC);
        step(); check_eq("s6_pc_wrap", out_pc, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        check_eq("s6_async_valid", 32'(out_valid), 32'd0);
        check_eq("s6_async_count", 32'(queue_count), 32'd0);
        check_eq("s6_async_pc", imem_pc, RESET_PC);
        do_reset();

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            fetch_en       = ($urandom_range(0, 9) != 0);
            out_ready      = ($urandom_range(0, 3) != 0);
            redirect_valid = ($urandom_range(0, 15) == 0);
            redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                         : $urandom();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
